// File: rtl/riscv_run_monitor.sv
// Run controller/checker: core reset sequencing, cycle/store counting, done-store detection.
// Optional fetch counter enabled by defining RUN_MONITOR_INST_CNT_EN.
module riscv_run_monitor #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int RST_CYCLES = 3,
  parameter int TIMEOUT    = 1000,
  parameter logic [ADDR_WIDTH-1:0] VERIFY_ADDR = 'h0,
  parameter logic [ADDR_WIDTH-1:0] DONE_ADDR   = 'hFC,
  parameter logic [DATA_WIDTH-1:0] PASS_CODE   = 'h1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_ce_i,
  input  logic                  data_we_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  inst_ce_i,
  output logic                  core_rst_o,
  output logic [2:0]            state_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [DATA_WIDTH-1:0] verify_o,
  output logic [CNT_WIDTH-1:0]  cycle_cnt_o,
  output logic [CNT_WIDTH-1:0]  store_cnt_o,
  output logic [CNT_WIDTH-1:0]  inst_cnt_o
);

  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [HW-1:0] hold_cnt;
  logic run, store, hit_verify, hit_done;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign run        = (state_q == S_RUN);
  assign store      = run & data_ce_i & data_we_i;
  assign hit_verify = store & (data_addr_i == VERIFY_ADDR);
  assign hit_done   = store & (data_addr_i == DONE_ADDR);
  assign state_o    = state_q;

  // A done-store in the final timeout cycle takes priority
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD:
        if (hold_cnt == HOLD_LAST) state_d = S_RUN;
      S_RUN:
        if (hit_done)
          state_d = (data_i == PASS_CODE) ? S_PASS : S_FAIL;
        else if (cycle_cnt_o == TO_LAST)
          state_d = S_TIMEOUT;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_HOLD;
      hold_cnt    <= '0;
      core_rst_o  <= 1'b1;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      verify_o    <= '0;
      cycle_cnt_o <= '0;
      store_cnt_o <= '0;
    end else begin
      state_q    <= state_d;
      core_rst_o <= (state_d != S_RUN);
      done_o     <= (state_d != S_RUN) && (state_d != S_HOLD);
      pass_o     <= (state_d == S_PASS);
      if (state_q == S_HOLD)
        hold_cnt <= hold_cnt + HW'(1);
      if (run)
        cycle_cnt_o <= sat_inc(cycle_cnt_o);
      if (store)
        store_cnt_o <= sat_inc(store_cnt_o);
      if (hit_verify)
        verify_o <= data_i;
    end
  end

`ifdef RUN_MONITOR_INST_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)
      inst_cnt_o <= '0;
    else if (run && inst_ce_i)
      inst_cnt_o <= sat_inc(inst_cnt_o);
  end
`else
  logic unused_inst_ce;
  assign unused_inst_ce = inst_ce_i;
  assign inst_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Scoreboard bench for riscv_run_monitor: directed scenarios plus random traffic.
// Expected values come from a transaction-level model of the run rules.
module tb_riscv_run_monitor;

  localparam int RSTC = 3;
  localparam int TO   = 10;
  localparam logic [31:0] VADDR = 32'h0;
  localparam logic [31:0] DADDR = 32'hFC;
  localparam logic [31:0] PCODE = 32'h1;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_ce_i, data_we_i, inst_ce_i;
  logic [31:0] data_addr_i, data_i;
  logic        core_rst_o, done_o, pass_o;
  logic [2:0]  state_o;
  logic [31:0] verify_o, cycle_cnt_o, store_cnt_o, inst_cnt_o;

  riscv_run_monitor #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(32),
    .RST_CYCLES(RSTC), .TIMEOUT(TO),
    .VERIFY_ADDR(VADDR), .DONE_ADDR(DADDR), .PASS_CODE(PCODE)
  ) dut (
    .clk(clk), .rst(rst),
    .data_ce_i(data_ce_i), .data_we_i(data_we_i),
    .data_addr_i(data_addr_i), .data_i(data_i),
    .inst_ce_i(inst_ce_i),
    .core_rst_o(core_rst_o), .state_o(state_o),
    .done_o(done_o), .pass_o(pass_o), .verify_o(verify_o),
    .cycle_cnt_o(cycle_cnt_o), .store_cnt_o(store_cnt_o),
    .inst_cnt_o(inst_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic        crst, done, pass;
    logic [31:0] ver, cyc, sc, ic;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Model: phase 0 hold, 1 run, 2 pass, 3 fail, 4 timeout
  int          m_st = 0;
  int          m_hold = 0;
  longint      m_cyc = 0, m_sc = 0, m_ic = 0;
  logic [31:0] m_ver = 0;

  function automatic longint sat(input longint v);
    return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
  endfunction

  task automatic model_step(input logic r, input logic ce, input logic we,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic ice);
    exp_t e;
    bit   wr;
    if (!r) begin
      m_st = 0; m_hold = 0; m_cyc = 0; m_sc = 0; m_ic = 0; m_ver = 0;
    end else if (m_st == 0) begin
      m_hold++;
      if (m_hold == RSTC) m_st = 1;
    end else if (m_st == 1) begin
      wr = ce && we;
      m_cyc = sat(m_cyc);
      if (wr) m_sc = sat(m_sc);
      if (ice) m_ic = sat(m_ic);
      if (wr && a == VADDR) m_ver = d;
      if (wr && a == DADDR) m_st = (d == PCODE) ? 2 : 3;
      else if (m_cyc == TO) m_st = 4;
    end
    e.st   = 3'(m_st);
    e.crst = (m_st != 1);
    e.done = (m_st >= 2);
    e.pass = (m_st == 2);
    e.ver  = m_ver;
    e.cyc  = 32'(m_cyc);
    e.sc   = 32'(m_sc);
`ifdef RUN_MONITOR_INST_CNT_EN
    e.ic   = 32'(m_ic);
`else
    e.ic   = 32'h0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic ce, input logic we,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic ice);
    @(negedge clk);
    rst = r; data_ce_i = ce; data_we_i = we;
    data_addr_i = a; data_i = d; inst_ce_i = ice;
    model_step(r, ce, we, a, d, ice);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 32'h40, 32'h0, 0);
  endtask

  task automatic do_reset_to_run();
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < RSTC + 2 && m_st == 0; i++) idle(1);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive(1, 1, 1, a, d, 0);
  endtask

  // Monitor: one comparison per clock once expectations exist
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (state_o !== e.st || core_rst_o !== e.crst || done_o !== e.done ||
          pass_o !== e.pass || verify_o !== e.ver || cycle_cnt_o !== e.cyc ||
          store_cnt_o !== e.sc || inst_cnt_o !== e.ic) begin
        n_err++;
        $display("FAIL cycle_check t=%0t got st=%0d crst=%0b done=%0b pass=%0b ver=%h cyc=%0d sc=%0d ic=%0d exp st=%0d crst=%0b done=%0b pass=%0b ver=%h cyc=%0d sc=%0d ic=%0d",
                 $time, state_o, core_rst_o, done_o, pass_o, verify_o,
                 cycle_cnt_o, store_cnt_o, inst_cnt_o, e.st, e.crst, e.done,
                 e.pass, e.ver, e.cyc, e.sc, e.ic);
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    int k;
    rst = 0; data_ce_i = 0; data_we_i = 0;
    data_addr_i = 0; data_i = 0; inst_ce_i = 0;

    // reset release, verify capture, pass
    do_reset_to_run();
    idle(2);
    store(VADDR, 32'h2A);
    store(DADDR, 32'h1);
    store(VADDR, 32'h77);
    idle(2);

    // fail, later stores frozen
    do_reset_to_run();
    store(32'h8, 32'h3);
    store(DADDR, 32'h5);
    store(DADDR, 32'h1);
    store(32'h8, 32'h9);
    idle(2);

    // timeout with no stores
    do_reset_to_run();
    idle(TO + 3);

    // done-store in the timeout cycle wins
    do_reset_to_run();
    for (int i = 0; i < TO && m_cyc < TO - 1; i++) idle(1);
    store(DADDR, 32'h1);
    idle(2);

    // reset mid-run
    do_reset_to_run();
    store(VADDR, 32'h55);
    idle(4);
    drive(0, 0, 0, 0, 0, 0);
    idle(1);

    // fetch counting and write without enable
    do_reset_to_run();
    for (int i = 0; i < 7; i++) drive(1, 0, 1, 32'h10, 32'h1, 1);
    drive(1, 0, 1, DADDR, 32'h1, 0);
    idle(2);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      k = int'($urandom_range(0, 3));
      case (k)
        0: a = VADDR;
        1: a = DADDR;
        2: a = 32'h8;
        default: a = $urandom;
      endcase
      d = ($urandom_range(0, 2) == 0) ? PCODE : $urandom;
      if (a == DADDR && $urandom_range(0, 3) != 0) a = 32'h8;
      drive(($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom),
            a, d, 1'($urandom));
    end

    idle(2);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain got=%0d left required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
